// File: rtl/rvga_ddr_arb_if.sv
// -----------------------------------------------------------------------------
// rvga_ddr_arb_if
// Purpose : one request/response bus of the rvga memory path. The same bundle
//           is used for the instruction-side and data-side requester ports and
//           for the shared downstream DDR controller port.
// Signals : addr  [WORD_W] address
//           read  [1]      read request / strobe, level, held until resp
//           write [1]      write request / strobe, level, held until resp
//           wdata [WORD_W] write data
//           rdata [WORD_W] read data, valid with resp
//           resp  [1]      one-cycle completion pulse
// Modports: master - issues requests (drives addr/read/write/wdata)
//           slave  - serves requests (drives rdata/resp)
// -----------------------------------------------------------------------------
interface rvga_ddr_arb_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] addr;
  logic              read;
  logic              write;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              resp;

  modport master (
    output addr, read, write, wdata,
    input  rdata, resp
  );

  modport slave (
    input  addr, read, write, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/rvga_ddr_arb.sv
// -----------------------------------------------------------------------------
// rvga_ddr_arb
// Purpose : serializes the rvga core's instruction-side and data-side memory
//           requests onto one DDR controller port, one transaction at a time.
//           A granted request is registered onto the downstream port, held
//           until the controller answers, and the captured read data is
//           returned to the owner together with a one-cycle resp pulse.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           iddr   - instruction-side requester bus (slave modport)
//           dddr   - data-side requester bus (slave modport)
//           mem    - downstream DDR controller bus (master modport)
// Build   : RVGA_ARB_RR_EN defined   -> round-robin on simultaneous requests
//           RVGA_ARB_RR_EN undefined -> fixed priority, data side wins ties
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module rvga_ddr_arb #(
  parameter int WORD_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  rvga_ddr_arb_if.slave  iddr,
  rvga_ddr_arb_if.slave  dddr,
  rvga_ddr_arb_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [WORD_W-1:0] r_rdata;
  logic              r_iddr_resp;
  logic              r_dddr_resp;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_grant;
  logic              w_done;
  logic              w_winner;
  logic [WORD_W-1:0] w_sel_addr;
  logic [WORD_W-1:0] w_sel_wdata;
  logic              w_sel_read;
  logic              w_sel_write;

  assign w_req_i = iddr.read | iddr.write;
  assign w_req_d = dddr.read | dddr.write;
  assign w_grant = (r_state == S_IDLE) && (w_req_i || w_req_d);
  assign w_done  = (r_state == S_BUSY) && mem.resp;

`ifdef RVGA_ARB_RR_EN
  logic r_last_grant;

  // On a tie the side that did not win last time goes first; with a single
  // requester w_req_d alone picks it.
  assign w_winner = (w_req_i && w_req_d) ? ~r_last_grant : w_req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= OWN_I;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
    end
  end
`else
  // Data side wins whenever it requests.
  assign w_winner = w_req_d;
`endif

  assign w_sel_addr  = (w_winner == OWN_D) ? dddr.addr  : iddr.addr;
  assign w_sel_wdata = (w_winner == OWN_D) ? dddr.wdata : iddr.wdata;
  assign w_sel_write = (w_winner == OWN_D) ? dddr.write : iddr.write;
  // A read+write request is treated as a write.
  assign w_sel_read  = ((w_winner == OWN_D) ? dddr.read : iddr.read) & ~w_sel_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_i || w_req_d) w_state_next = S_BUSY;
      S_BUSY:  if (mem.resp)           w_state_next = S_RESP;
      S_RESP:                          w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_I;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rdata     <= '0;
      r_iddr_resp <= 1'b0;
      r_dddr_resp <= 1'b0;
    end else begin
      // The resp flops are high exactly for the cycle spent in S_RESP.
      r_iddr_resp <= w_done && (r_owner == OWN_I);
      r_dddr_resp <= w_done && (r_owner == OWN_D);
      if (w_grant) begin
        r_owner     <= w_winner;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_read  <= w_sel_read;
        r_mem_write <= w_sel_write;
      end else if (w_done) begin
        // Captured for writes too; requesters ignore it then.
        r_rdata     <= mem.rdata;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  assign mem.addr   = r_mem_addr;
  assign mem.wdata  = r_mem_wdata;
  assign mem.read   = r_mem_read;
  assign mem.write  = r_mem_write;
  assign iddr.rdata = r_rdata;
  assign dddr.rdata = r_rdata;
  assign iddr.resp  = r_iddr_resp;
  assign dddr.resp  = r_dddr_resp;

endmodule

// File: tb/tb_rvga_ddr_arb.sv
// -----------------------------------------------------------------------------
// tb_rvga_ddr_arb
// Directed scenarios with literal expectations, followed by randomized
// requesters, a random-latency memory responder and occasional resets. A
// transaction-level model predicts the arbiter outputs every cycle.
// -----------------------------------------------------------------------------
module tb_rvga_ddr_arb;
  localparam int W = 32;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rvga_ddr_arb_if #(.WORD_W(W)) iddr_bus ();
  rvga_ddr_arb_if #(.WORD_W(W)) dddr_bus ();
  rvga_ddr_arb_if #(.WORD_W(W)) mem_bus ();

  rvga_ddr_arb #(.WORD_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .iddr (iddr_bus),
    .dddr (dddr_bus),
    .mem  (mem_bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // e_rd/e_wr describe the outstanding downstream transaction; a pending
  // e_iresp/e_dresp means the completion is being reported this cycle.
  logic        e_rd = 0, e_wr = 0, e_iresp = 0, e_dresp = 0;
  logic        e_owner = SIDE_I, e_last = SIDE_I;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;

  always @(posedge clk) begin
    logic ri, rd, win;
    ri = iddr_bus.read | iddr_bus.write;
    rd = dddr_bus.read | dddr_bus.write;
    if (!rst_n) begin
      e_rd = 0; e_wr = 0; e_iresp = 0; e_dresp = 0;
      e_addr = 0; e_wdata = 0; e_rdata = 0;
      e_owner = SIDE_I; e_last = SIDE_I;
    end else if (e_iresp || e_dresp) begin
      // completion reported; arbiter returns to sampling
      e_iresp = 0; e_dresp = 0;
    end else if (e_rd || e_wr) begin
      if (mem_bus.resp) begin
        e_rdata = mem_bus.rdata;
        e_rd = 0; e_wr = 0;
        if (e_owner == SIDE_I) e_iresp = 1; else e_dresp = 1;
      end
    end else if (ri || rd) begin
      if (ri && rd) begin
`ifdef RVGA_ARB_RR_EN
        win = (e_last == SIDE_D) ? SIDE_I : SIDE_D;
`else
        win = SIDE_D;
`endif
      end else begin
        win = rd ? SIDE_D : SIDE_I;
      end
      if (win == SIDE_D) begin
        e_wr = dddr_bus.write; e_rd = dddr_bus.read && !dddr_bus.write;
        e_addr = dddr_bus.addr; e_wdata = dddr_bus.wdata;
      end else begin
        e_wr = iddr_bus.write; e_rd = iddr_bus.read && !iddr_bus.write;
        e_addr = iddr_bus.addr; e_wdata = iddr_bus.wdata;
      end
      e_owner = win;
      e_last  = win;
    end
    #1;
    check("mem_read",  mem_bus.read,  e_rd);
    check("mem_write", mem_bus.write, e_wr);
    check("mem_addr",  mem_bus.addr,  e_addr);
    check("mem_wdata", mem_bus.wdata, e_wdata);
    check("iddr_resp", iddr_bus.resp, e_iresp);
    check("dddr_resp", dddr_bus.resp, e_dresp);
    if (e_iresp) check("iddr_rdata", iddr_bus.rdata, e_rdata);
    if (e_dresp) check("dddr_rdata", dddr_bus.rdata, e_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mem_answer(input logic [31:0] data);
    mem_bus.resp  = 1'b1;
    mem_bus.rdata = data;
    tick();
    mem_bus.resp  = 1'b0;
  endtask

  int lat_left = -1;

  initial begin
    int mode;
    iddr_bus.read = 0; iddr_bus.write = 0; iddr_bus.addr = 0; iddr_bus.wdata = 0;
    dddr_bus.read = 0; dddr_bus.write = 0; dddr_bus.addr = 0; dddr_bus.wdata = 0;
    mem_bus.resp = 0; mem_bus.rdata = 0;
    rst_n = 0;

    // Reset held with a pending instruction read
    iddr_bus.read = 1; iddr_bus.addr = 32'h0000_0100;
    repeat (3) begin
      tick();
      check("rst_mem_read",  mem_bus.read,  0);
      check("rst_iddr_resp", iddr_bus.resp, 0);
      check("rst_mem_addr",  mem_bus.addr,  0);
    end
    rst_n = 1;
    tick();
    check("rel_mem_read", mem_bus.read, 1);
    check("rel_mem_addr", mem_bus.addr, 32'h0000_0100);
    mem_answer(32'hCAFE_0001);
    check("rel_iddr_resp",  iddr_bus.resp,  1);
    check("rel_iddr_rdata", iddr_bus.rdata, 32'hCAFE_0001);
    iddr_bus.read = 0;
    tick();

    // Single data read, answer 3 cycles after mem_read rises
    dddr_bus.read = 1; dddr_bus.addr = 32'h2000;
    tick();
    check("rd_mem_read", mem_bus.read, 1);
    check("rd_mem_addr", mem_bus.addr, 32'h2000);
    repeat (3) begin
      tick();
      check("rd_hold", mem_bus.read, 1);
    end
    mem_answer(32'hDEAD_BEEF);
    check("rd_dddr_resp",  dddr_bus.resp,  1);
    check("rd_dddr_rdata", dddr_bus.rdata, 32'hDEAD_BEEF);
    check("rd_iddr_resp",  iddr_bus.resp,  0);
    check("rd_strobe_off", mem_bus.read,   0);
    dddr_bus.read = 0;
    tick();
    check("rd_resp_1cyc", dddr_bus.resp, 0);

    // Stray resp while idle
    mem_answer(32'h5555_5555);
    check("stray_iresp", iddr_bus.resp,  0);
    check("stray_dresp", dddr_bus.resp,  0);
    check("stray_rdata", dddr_bus.rdata, 32'hDEAD_BEEF);
    tick();

    // Tie after reset
    rst_n = 0;
    tick();
    rst_n = 1;
    iddr_bus.read  = 1; iddr_bus.addr  = 32'h40;
    dddr_bus.write = 1; dddr_bus.addr  = 32'h80; dddr_bus.wdata = 32'h1234;
    tick();
    check("tie1_write", mem_bus.write, 1);
    check("tie1_read",  mem_bus.read,  0);
    check("tie1_addr",  mem_bus.addr,  32'h80);
    check("tie1_wdata", mem_bus.wdata, 32'h1234);
    mem_answer(32'h0);
    check("tie1_dresp", dddr_bus.resp, 1);
    dddr_bus.addr = 32'h84; dddr_bus.wdata = 32'h5678;   // new data-side write
    tick();
    tick();
`ifdef RVGA_ARB_RR_EN
    check("tie2_read", mem_bus.read, 1);
    check("tie2_addr", mem_bus.addr, 32'h40);
    mem_answer(32'h0);
    check("tie2_iresp", iddr_bus.resp, 1);
    iddr_bus.read = 0;
    tick();
    tick();
    check("tie3_write", mem_bus.write, 1);
    check("tie3_addr",  mem_bus.addr,  32'h84);
    mem_answer(32'h0);
    check("tie3_dresp", dddr_bus.resp, 1);
`else
    check("tie2_write", mem_bus.write, 1);
    check("tie2_addr",  mem_bus.addr,  32'h84);
    mem_answer(32'h0);
    check("tie2_dresp", dddr_bus.resp, 1);
    dddr_bus.write = 0;
    tick();
    tick();
    check("tie3_read", mem_bus.read, 1);
    check("tie3_addr", mem_bus.addr, 32'h40);
    mem_answer(32'h0);
    check("tie3_iresp", iddr_bus.resp, 1);
`endif
    iddr_bus.read = 0; dddr_bus.write = 0;
    tick();

    // Read+write on one side counts as a write
    dddr_bus.read = 1; dddr_bus.write = 1; dddr_bus.addr = 32'h300;
    tick();
    check("rw_write", mem_bus.write, 1);
    check("rw_read",  mem_bus.read,  0);
    mem_answer(32'h0);
    check("rw_dresp", dddr_bus.resp, 1);
    dddr_bus.read = 0; dddr_bus.write = 0;
    tick();

    // Reset in the middle of a transaction
    iddr_bus.read = 1; iddr_bus.addr = 32'h500;
    tick();
    check("mid_read", mem_bus.read, 1);
    tick();
    #1 rst_n = 0;
    #1 check("mid_async_drop", mem_bus.read, 0);
    tick();
    check("mid_no_resp", iddr_bus.resp, 0);
    rst_n = 1;
    tick();
    check("mid_regrant", mem_bus.read, 1);
    check("mid_re_addr", mem_bus.addr, 32'h500);
    mem_answer(32'h0BAD_F00D);
    check("mid_iresp", iddr_bus.resp, 1);
    iddr_bus.read = 0;
    tick();

    // Randomized traffic
    repeat (3000) begin
      tick();
      if (iddr_bus.resp || !(iddr_bus.read || iddr_bus.write)) begin
        if ($urandom_range(0, 2) == 0) begin
          mode = int'($urandom_range(0, 2));
          iddr_bus.read  = (mode != 1);
          iddr_bus.write = (mode != 0);
          iddr_bus.addr  = $urandom;
          iddr_bus.wdata = $urandom;
        end else if (iddr_bus.resp) begin
          iddr_bus.read = 0; iddr_bus.write = 0;
        end
      end
      if (dddr_bus.resp || !(dddr_bus.read || dddr_bus.write)) begin
        if ($urandom_range(0, 2) == 0) begin
          mode = int'($urandom_range(0, 2));
          dddr_bus.read  = (mode != 1);
          dddr_bus.write = (mode != 0);
          dddr_bus.addr  = $urandom;
          dddr_bus.wdata = $urandom;
        end else if (dddr_bus.resp) begin
          dddr_bus.read = 0; dddr_bus.write = 0;
        end
      end
      if (mem_bus.read || mem_bus.write) begin
        if (lat_left < 0) lat_left = int'($urandom_range(0, 3));
        if (lat_left == 0) begin
          mem_bus.resp  = 1;
          mem_bus.rdata = $urandom;
          lat_left = -1;
        end else begin
          mem_bus.resp = 0;
          lat_left--;
        end
      end else begin
        lat_left = -1;
        mem_bus.resp  = ($urandom_range(0, 7) == 0);
        mem_bus.rdata = $urandom;
      end
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 499) == 0) rst_n = 0;
    end

    iddr_bus.read = 0; iddr_bus.write = 0;
    dddr_bus.read = 0; dddr_bus.write = 0;
    mem_bus.resp = 0;
    rst_n = 1;
    repeat (8) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rvga_ddr_arb.md
# rvga_ddr_arb

Two-port memory arbiter sitting directly below the rvga core. It takes the core's instruction-side (`iddr_*`) and data-side (`dddr_*`) request interfaces and serializes them onto one shared DDR controller port. It registers each granted request, forwards it downstream, and returns the captured response to the requesting side as a one-cycle `*_resp` pulse. The core stalls on any outstanding request, so the arbiter handles at most one transaction at a time.

## Interface
- `WORD_W`, 32: address and data width (one `rvga_word`).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `iddr_addr` input WORD_W: instruction-side address.
- `iddr_read` input 1: instruction-side read request, level, held until `iddr_resp`.
- `iddr_write` input 1: instruction-side write request, level, held until `iddr_resp`.
- `iddr_wdata` input WORD_W: instruction-side write data.
- `iddr_rdata` output WORD_W: instruction-side read data, valid while `iddr_resp`=1.
- `iddr_resp` output 1: instruction-side completion pulse, one cycle.
- `dddr_addr`, `dddr_read`, `dddr_write`, `dddr_wdata`, `dddr_rdata`, `dddr_resp`: same set for the data side.
- `mem_addr` output WORD_W: registered downstream address.
- `mem_read` output 1: downstream read strobe, held until `mem_resp`.
- `mem_write` output 1: downstream write strobe, held until `mem_resp`.
- `mem_wdata` output WORD_W: registered downstream write data.
- `mem_rdata` input WORD_W: downstream read data, sampled when `mem_resp`=1.
- `mem_resp` input 1: downstream completion, one cycle.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: the arbiter samples requests. A side is requesting when its `read|write` is 1. If no side is requesting, it stays in IDLE. If a side is requesting, the arbiter selects a winner (see Configuration), latches the winner's addr, wdata, read and write into the `mem_*` registers, records the owner, and moves to BUSY.
- If `read` and `write` are both 1 on one side, the request is a write and the read is ignored.
- BUSY: `mem_*` outputs stay constant. On `mem_resp`=1, the arbiter captures `mem_rdata` into a shared rdata register, deasserts `mem_read` and `mem_write` (registered), and moves to RESP.
- RESP: the owner's `*_resp` is 1 for exactly this cycle. The other side's resp stays 0. Next state is always IDLE.
- Requests are not sampled in BUSY or RESP. The requester's updated or dropped request is sampled in the following IDLE cycle.
- `iddr_rdata` and `dddr_rdata` both drive the shared rdata register. The value is only meaningful with the corresponding resp.
- For writes, the rdata register still captures `mem_rdata`. Requesters ignore it.
- `mem_resp` in IDLE or RESP is ignored.
- Reset, asserted at any time including mid-transaction:
  - State goes to IDLE.
  - `mem_read`=`mem_write`=0.
  - `mem_addr`=`mem_wdata`=0.
  - rdata=0.
  - `iddr_resp`=`dddr_resp`=0.
  - Last-grant register = instruction side.
  - An in-flight transaction is abandoned with no resp.

## Timing
- Request visible in IDLE at cycle N: `mem_read` or `mem_write` is 1 from cycle N+1.
- `mem_resp` at cycle M: `mem_*` strobes are 0 at M+1, and `*_resp`=1 with valid rdata at M+1.
- Minimum round trip, with `mem_resp` at N+1: resp at N+2, next grant sampled at N+3 and visible on `mem_*` at N+4.
- Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- Outputs depend only on registers. There is no combinational path from any input to any output.

## Configuration
- `RVGA_ARB_RR_EN` defined: round-robin arbitration.
  - When both sides request in IDLE, the side not recorded in the last-grant register wins.
  - Last-grant is updated on every grant.
- `RVGA_ARB_RR_EN` undefined: fixed priority, data side always wins on a tie.
  - The last-grant register is not implemented.
- Single-requester behavior is identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 with `iddr_read`=1 -> `mem_read`=0, `iddr_resp`=0, `mem_addr`=0 throughout. After release, `mem_read`=1 with `mem_addr`=`iddr_addr`=0x0000_0100 one cycle after the first IDLE sample.
- Single read: `dddr_read`=1, `dddr_addr`=0x2000, `mem_resp` 3 cycles after `mem_read` rises with `mem_rdata`=0xDEADBEEF -> `dddr_resp`=1 for one cycle the next cycle, `dddr_rdata`=0xDEADBEEF, `iddr_resp`=0.
- Simultaneous requests, `iddr_read`@0x40 and `dddr_write`@0x80 with `wdata`=0x1234:
  - Without the macro: data side granted first (`mem_write`=1, `mem_addr`=0x80), then instruction side.
  - With the macro after reset: data side granted first, and on the next tie the instruction side is granted.
- Read+write on one side: `dddr_read`=`dddr_write`=1 -> `mem_write`=1, `mem_read`=0.
- Stray resp: `mem_resp`=1 while idle -> no `*_resp`, rdata unchanged.
- Mid-transaction reset: assert `rst_n`=0 in BUSY -> `mem_read` drops asynchronously, no resp issued, and after release the held request is re-granted.
